// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: command encodings, SDA engine state codes
// and the master FSM state codes that drive them.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_HI  = 4'd1;
    localparam logic [3:0] ST_START_LO  = 4'd2;
    localparam logic [3:0] ST_HOLD      = 4'd3;
    localparam logic [3:0] ST_WR_BIT    = 4'd4;
    localparam logic [3:0] ST_WR_ACK    = 4'd5;
    localparam logic [3:0] ST_RD_BIT    = 4'd6;
    localparam logic [3:0] ST_RD_ACK    = 4'd7;
    localparam logic [3:0] ST_STOP_LO   = 4'd8;
    localparam logic [3:0] ST_STOP_WAIT = 4'd9;

    // Master FSM state codes, kept here so both FSMs share one encoding file.
    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_START = 3'd1;
    localparam logic [2:0] M_ADDR  = 3'd2;
    localparam logic [2:0] M_WRITE = 3'd3;
    localparam logic [2:0] M_READ  = 3'd4;
    localparam logic [2:0] M_STOP  = 3'd5;
    localparam logic [2:0] M_ERROR = 3'd6;

endpackage

// File: rtl/scl_edge_detect.sv
// Registers the generated scl and produces one-clk rise/fall pulses.
module scl_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    output logic scl_q,
    output logic rise,
    output logic fall
);

    // Idle bus level is high, so reset scl_q high to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 1'b1;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            scl_q <= scl;
        end
    end

    assign rise = scl & ~scl_q;
    assign fall = ~scl & scl_q;

endmodule

// File: rtl/sda_shift_engine.sv
// Byte-level SDA engine: executes START, WRITE+ACK, READ+ACK/NACK and STOP
// in lock-step with scl edges and reports completion to the master FSM.
module sda_shift_engine
    import i2c_pkg::*;
#(
    parameter int DATA_LEN  = 8,
    parameter int STOP_HOLD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scl,
    input  logic                sda_in,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                ack_n_in,
    output logic                cmd_ready,
    output logic                sda_o,
    output logic                done,
    output logic                err,
    output logic                ack_n,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                busy
);

    logic                scl_q;
    logic                rise;
    logic                fall;
    logic [3:0]          state;
    logic [3:0]          bit_cnt;
    logic [DATA_LEN-1:0] tx_sh;
    logic [DATA_LEN-1:0] rx_sh;
    logic                ack_n_q;
    logic                accept;

    scl_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .scl   (scl),
        .scl_q (scl_q),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        // NOTE: default first so every path assigns cmd_ready and no latch is inferred.
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_HOLD: cmd_ready = ~scl;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign accept = cmd_valid & cmd_ready;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sda_o   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            ack_n   <= 1'b1;
            rx_data <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            ack_n_q <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sda_o <= 1'b1;
                    if (accept) begin
                        if (cmd == CMD_START) begin
                            state <= ST_START_HI;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                ST_START_HI: begin
                    if (scl && scl_q) begin
                        sda_o <= 1'b0;
                        state <= ST_START_LO;
                    end
                end
                ST_START_LO: begin
                    if (fall) begin
                        done  <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        case (cmd)
                            CMD_START: begin
                                sda_o <= 1'b1;
                                state <= ST_START_HI;
                            end
                            CMD_WRITE: begin
                                tx_sh   <= tx_data;
                                sda_o   <= tx_data[DATA_LEN-1];
                                bit_cnt <= 4'd1;
                                state   <= ST_WR_BIT;
                            end
                            CMD_READ: begin
                                sda_o   <= 1'b1;
                                ack_n_q <= ack_n_in;
                                bit_cnt <= '0;
                                state   <= ST_RD_BIT;
                            end
                            CMD_STOP: begin
                                sda_o <= 1'b0;
                                state <= ST_STOP_LO;
                            end
                        endcase
                    end
                end
                ST_WR_BIT: begin
                    // bit_cnt counts bits already placed on SDA.
                    if (fall) begin
                        if (bit_cnt == 4'(DATA_LEN)) begin
                            sda_o   <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_WR_ACK;
                        end else begin
                            sda_o   <= tx_sh[DATA_LEN-2];
                            tx_sh   <= {tx_sh[DATA_LEN-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (rise) begin
                        ack_n <= sda_in;
                    end else if (fall) begin
                        sda_o <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_RD_BIT: begin
                    if (rise && bit_cnt != 4'(DATA_LEN)) begin
                        rx_sh   <= {rx_sh[DATA_LEN-2:0], sda_in};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (fall && bit_cnt == 4'(DATA_LEN)) begin
                        sda_o   <= ack_n_q;
                        bit_cnt <= '0;
                        state   <= ST_RD_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (fall) begin
                        rx_data <= rx_sh;
                        sda_o   <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_STOP_LO: begin
                    sda_o <= 1'b0;
                    if (rise) begin
                        bit_cnt <= '0;
                        state   <= ST_STOP_WAIT;
                    end
                end
                ST_STOP_WAIT: begin
                    // The bit counter doubles as the STOP setup timer.
                    if (bit_cnt == 4'(STOP_HOLD - 1)) begin
                        sda_o   <= 1'b1;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    sda_o <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sda_shift_engine.sv
// Directed bench for sda_shift_engine: scl is driven by hand with a 4-clk
// period; inputs change and outputs are sampled on the falling clk edge.
module tb_sda_shift_engine;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_in;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       ack_n_in;
    logic       cmd_ready;
    logic       sda_o;
    logic       done;
    logic       err;
    logic       ack_n;
    logic [7:0] rx_data;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sda_shift_engine #(.DATA_LEN(8), .STOP_HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .ack_n_in  (ack_n_in),
        .cmd_ready (cmd_ready),
        .sda_o     (sda_o),
        .done      (done),
        .err       (err),
        .ack_n     (ack_n),
        .rx_data   (rx_data),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Called from HOLD with scl low; returns in HOLD with scl low for 2 clk.
    task automatic do_write(input logic [7:0] data, input logic ack_bit);
        tx_data = data;
        issue(C_WRITE);
        check1("wr_first_bit", sda_o, data[7]);
        check1("wr_ready_low", cmd_ready, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            scl = 1'b1;
            tick(1);
            check1($sformatf("wr_%h_bit%0d", data, i), sda_o, data[i]);
            tick(1);
            scl = 1'b0;
            tick(2);
        end
        sda_in = ack_bit;
        scl    = 1'b1;
        tick(1);
        check1("wr_ack_release", sda_o, 1'b1);
        check1("wr_no_early_done", done, 1'b0);
        tick(1);
        scl = 1'b0;
        tick(1);
        sda_in = 1'b1;
        check1("wr_done", done, 1'b1);
        check1("wr_err", err, 1'b0);
        check1("wr_ack_n", ack_n, ack_bit);
        check1("wr_hold_sda", sda_o, 1'b0);
        tick(1);
        check1("wr_done_pulse", done, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] data, input logic ackn, input logic [7:0] prev);
        ack_n_in = ackn;
        issue(C_READ);
        ack_n_in = ~ackn;
        check1("rd_release", sda_o, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            sda_in = data[i];
            scl    = 1'b1;
            tick(1);
            check1($sformatf("rd_bit%0d_release", i), sda_o, 1'b1);
            tick(1);
            scl = 1'b0;
            tick(2);
        end
        sda_in = 1'b1;
        scl    = 1'b1;
        tick(1);
        check1("rd_ack_bit", sda_o, ackn);
        check8("rd_data_held", rx_data, prev);
        tick(1);
        scl = 1'b0;
        tick(1);
        check1("rd_done", done, 1'b1);
        check1("rd_err", err, 1'b0);
        check8("rd_data", rx_data, data);
        check1("rd_hold_sda", sda_o, 1'b0);
        tick(1);
        check1("rd_done_pulse", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        scl       = 1'b1;
        sda_in    = 1'b1;
        cmd_valid = 1'b0;
        cmd       = C_START;
        tx_data   = 8'h00;
        ack_n_in  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check1("rst_sda", sda_o, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ack_n", ack_n, 1'b1);
        check1("rst_ready", cmd_ready, 1'b1);
        check1("rst_done", done, 1'b0);
        check8("rst_rx", rx_data, 8'h00);

        // START from IDLE with scl high
        issue(C_START);
        check1("st_busy", busy, 1'b1);
        check1("st_sda_hi", sda_o, 1'b1);
        check1("st_ready_low", cmd_ready, 1'b0);
        tick(1);
        check1("st_sda_fall", sda_o, 1'b0);
        check1("st_scl_high", scl, 1'b1);
        check1("st_no_early_done", done, 1'b0);
        scl = 1'b0;
        tick(1);
        check1("st_done", done, 1'b1);
        check1("st_err", err, 1'b0);
        tick(1);
        check1("st_done_pulse", done, 1'b0);
        check1("hold_ready", cmd_ready, 1'b1);

        do_write(8'h81, 1'b1);
        do_write(8'hA5, 1'b0);
        do_read(8'h3C, 1'b1, 8'h00);
        do_read(8'hC3, 1'b0, 8'h3C);

        // Repeated START from HOLD
        issue(C_START);
        check1("rs_sda_release", sda_o, 1'b1);
        scl = 1'b1;
        tick(1);
        check1("rs_sda_wait", sda_o, 1'b1);
        check1("rs_ready_low", cmd_ready, 1'b0);
        tick(1);
        check1("rs_sda_fall", sda_o, 1'b0);
        scl = 1'b0;
        tick(1);
        check1("rs_done", done, 1'b1);
        tick(1);

        // STOP from HOLD
        issue(C_STOP);
        check1("sp_sda_low", sda_o, 1'b0);
        check1("sp_busy", busy, 1'b1);
        scl = 1'b1;
        tick(1);
        check1("sp_sda_rise", sda_o, 1'b0);
        tick(1);
        check1("sp_sda_setup", sda_o, 1'b0);
        check1("sp_no_early_done", done, 1'b0);
        tick(1);
        check1("sp_sda_release", sda_o, 1'b1);
        check1("sp_done", done, 1'b1);
        check1("sp_err", err, 1'b0);
        check1("sp_idle", busy, 1'b0);
        tick(1);
        check1("sp_done_pulse", done, 1'b0);
        check1("sp_ready", cmd_ready, 1'b1);

        // Illegal commands in IDLE
        issue(C_WRITE);
        check1("il_wr_done", done, 1'b1);
        check1("il_wr_err", err, 1'b1);
        check1("il_wr_sda", sda_o, 1'b1);
        check1("il_wr_busy", busy, 1'b0);
        tick(1);
        check1("il_wr_done_pulse", done, 1'b0);
        check1("il_wr_err_pulse", err, 1'b0);
        issue(C_STOP);
        check1("il_sp_err", err, 1'b1);
        check1("il_sp_busy", busy, 1'b0);
        tick(1);

        // Reset during bit 4 of a WRITE
        issue(C_START);
        tick(1);
        scl = 1'b0;
        tick(2);
        tx_data = 8'hA5;
        issue(C_WRITE);
        for (int i = 0; i < 3; i++) begin
            scl = 1'b1;
            tick(2);
            scl = 1'b0;
            tick(2);
        end
        check1("rm_bit4_sda", sda_o, 1'b0);
        check1("rm_busy", busy, 1'b1);
        rst       = 1'b1;
        cmd       = C_START;
        cmd_valid = 1'b1;
        tick(1);
        check1("rm_sda", sda_o, 1'b1);
        check1("rm_busy_clr", busy, 1'b0);
        check1("rm_ack_n", ack_n, 1'b1);
        check8("rm_rx", rx_data, 8'h00);
        check1("rm_done", done, 1'b0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        tick(1);
        check1("rm_no_accept", busy, 1'b0);
        check1("rm_sda_idle", sda_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
